line_follow_ctrl: RTL

LINE_FOLLOW_CTRL -- requirements
Module: line_follow_ctrl

---
 rtl/line_follow_ctrl.sv | 132 +++++++++++++
 1 files changed

// File: rtl/line_follow_ctrl.sv
// Line-follower supervisor: decodes UART commands and barcode hits, and tracks
// line loss to gate the PID/forward-speed datapath.
module line_follow_ctrl #(
  parameter bit FAST_SIM = 1'b0
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] cmd,
  input  logic       cmd_rdy,
  output logic       clr_cmd_rdy,
  input  logic       BC_done,
  input  logic [7:0] BC_ID,
  input  logic       line_present,
  output logic       go,
  output logic       lost,
  output logic       in_transit
);

  localparam int unsigned ID_W  = 6;
  localparam int unsigned TMR_W = 20;
  localparam logic [TMR_W-1:0] LOST_CYC  = FAST_SIM ? 20'd1024 : 20'd1_000_000;
  localparam logic [TMR_W-1:0] LOST_LAST = LOST_CYC - TMR_W'(1);
  localparam logic [1:0] OP_STOP = 2'b00;
  localparam logic [1:0] OP_GO   = 2'b01;

  typedef enum logic [1:0] {IDLE, FOLLOW, LOST, HALT} state_t;

  state_t            state_q, state_d;
  logic [ID_W-1:0]   dest_q, dest_d;
  logic [ID_W-1:0]   pend_dest_q, pend_dest_d;
  logic              pend_q, pend_d;
  logic [TMR_W-1:0]  timer_q, timer_d;
  logic              lost_d, go_d, clr_d;

  logic cmd_v_c, is_stop_c, is_go_c, bc_match_c;

  // A command is fresh only when it has not been acknowledged in the previous cycle
  assign cmd_v_c    = cmd_rdy & ~clr_cmd_rdy;
  assign is_stop_c  = cmd_v_c & (cmd[7:6] == OP_STOP);
  assign is_go_c    = cmd_v_c & (cmd[7:6] == OP_GO);
  assign bc_match_c = BC_done & (BC_ID[7:6] == 2'b00) & (BC_ID[ID_W-1:0] == dest_q);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      dest_q      <= '0;
      pend_dest_q <= '0;
      pend_q      <= 1'b0;
      timer_q     <= '0;
      go          <= 1'b0;
      lost        <= 1'b0;
      in_transit  <= 1'b0;
      clr_cmd_rdy <= 1'b0;
    end else begin
      state_q     <= state_d;
      dest_q      <= dest_d;
      pend_dest_q <= pend_dest_d;
      pend_q      <= pend_d;
      timer_q     <= timer_d;
      go          <= go_d;
      lost        <= lost_d;
      in_transit  <= go_d;
      clr_cmd_rdy <= clr_d;
    end
  end

  // Priority: STOP > barcode match > GO > line change > timeout
  always_comb begin
    state_d     = state_q;
    dest_d      = dest_q;
    pend_dest_d = pend_dest_q;
    pend_d      = pend_q;
    timer_d     = timer_q;
    lost_d      = lost;
    clr_d       = cmd_v_c;

    case (state_q)
      IDLE: begin
        if (pend_q) begin
          dest_d  = pend_dest_q;
          pend_d  = 1'b0;
          lost_d  = 1'b0;
          timer_d = '0;
          state_d = FOLLOW;
        end else if (is_go_c) begin
          dest_d  = cmd[ID_W-1:0];
          lost_d  = 1'b0;
          timer_d = '0;
          state_d = FOLLOW;
        end
      end
      FOLLOW: begin
        if (is_stop_c || bc_match_c) begin
          state_d = HALT;
        end else if (is_go_c) begin
          dest_d = cmd[ID_W-1:0];
        end else if (!line_present) begin
          timer_d = '0;
          state_d = LOST;
        end
      end
      LOST: begin
        if (is_stop_c || bc_match_c) begin
          state_d = HALT;
        end else if (is_go_c) begin
          dest_d = cmd[ID_W-1:0];
        end else if (line_present) begin
          timer_d = '0;
          state_d = FOLLOW;
        end else if (timer_q == LOST_LAST) begin
          timer_d = '0;
          lost_d  = 1'b1;
          state_d = IDLE;
        end else begin
          timer_d = timer_q + TMR_W'(1);
        end
      end
      HALT: begin
        // A GO seen here is parked and launched from IDLE on the next cycle
        state_d = IDLE;
        if (is_go_c) begin
          pend_d      = 1'b1;
          pend_dest_d = cmd[ID_W-1:0];
        end
      end
      default: state_d = IDLE;
    endcase

    go_d = (state_d == FOLLOW) || (state_d == LOST);
  end

endmodule
